// File: rtl/mem_block_mover.sv
// mem_block_mover
//   Bus-master block copier for the 8-bit data-memory port. It copies len bytes
//   from src to dst with memmove semantics: when the destination overlaps the
//   tail of the source, the copy runs backward.
//
//   The memory strobes, address and write data are decoded from registered
//   state only. Because of this, an asynchronous reset drops mem_wr_en at once.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   i_start      command strobe, sampled only in IDLE
//   i_src        source base address, captured on accepted start
//   i_dst        destination base address, captured on accepted start
//   i_len        byte count, captured on accepted start (0 = no-op)
//   o_mem_addr   memory address
//   o_mem_rd     memory read enable
//   o_mem_wr_en  memory write enable
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data, combinational from o_mem_addr
//   o_busy       high in any state other than IDLE
//   o_done       one-cycle pulse at command completion
//   o_remaining  bytes not yet written
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; all memory outputs 0
// S_READ  | read byte at src+idx, latch into buffer
// S_WRITE | write buffer to dst+idx, decrement remaining, step idx
// S_DONE  | one-cycle done pulse, still busy
module mem_block_mover #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_start,
   input  logic [AW-1:0] i_src,
   input  logic [AW-1:0] i_dst,
   input  logic [AW-1:0] i_len,
   output logic [AW-1:0] o_mem_addr,
   output logic          o_mem_rd,
   output logic          o_mem_wr_en,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_busy,
   output logic          o_done,
   output logic [AW-1:0] o_remaining
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [AW-1:0] r_idx;
   logic [AW-1:0] r_remaining;
   logic [DW-1:0] r_buf;
   logic          r_bwd;

   logic [AW-1:0] w_delta;
   logic          w_bwd;
   logic          w_last;

   // A destination that lies inside the source window, above the source,
   // would be overwritten before it is read in a forward copy.
   // dst == src (delta 0) stays forward.
   assign w_delta = i_dst - i_src;
   assign w_bwd   = (w_delta != '0) && (w_delta < i_len);
   assign w_last  = (r_remaining == AW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next = (i_len == '0) ? S_DONE : S_READ;
            end
         end
         S_READ:  w_next = S_WRITE;
         S_WRITE: w_next = w_last ? S_DONE : S_READ;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src       <= '0;
         r_dst       <= '0;
         r_idx       <= '0;
         r_remaining <= '0;
         r_buf       <= '0;
         r_bwd       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_src       <= i_src;
                  r_dst       <= i_dst;
                  r_remaining <= i_len;
                  r_bwd       <= w_bwd;
                  r_idx       <= w_bwd ? (i_len - AW'(1)) : '0;
               end
            end
            S_READ: begin
               r_buf <= i_mem_rdata;
            end
            S_WRITE: begin
               r_remaining <= r_remaining - AW'(1);
               if (!w_last) begin
                  r_idx <= r_bwd ? (r_idx - AW'(1)) : (r_idx + AW'(1));
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      o_mem_addr  = '0;
      o_mem_rd    = 1'b0;
      o_mem_wr_en = 1'b0;
      o_mem_wdata = '0;
      o_done      = 1'b0;
      o_busy      = (r_state != S_IDLE);
      o_remaining = r_remaining;
      case (r_state)
         S_READ: begin
            o_mem_rd   = 1'b1;
            o_mem_addr = r_src + r_idx;
         end
         S_WRITE: begin
            o_mem_wr_en = 1'b1;
            o_mem_addr  = r_dst + r_idx;
            o_mem_wdata = r_buf;
         end
         S_DONE: begin
            o_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_block_mover.sv
module tb_mem_block_mover;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] src = '0, dst = '0, len = '0;
   logic [7:0] mem_addr, mem_wdata, mem_rdata, remaining;
   logic       mem_rd, mem_wr_en, busy, done;

   logic [7:0] dmem [256];
   logic [7:0] refm [256];
   logic       bd_we = 1'b0;
   logic [7:0] bd_addr = '0, bd_data = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_block_mover #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(start),
      .i_src(src), .i_dst(dst), .i_len(len),
      .o_mem_addr(mem_addr), .o_mem_rd(mem_rd), .o_mem_wr_en(mem_wr_en),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_busy(busy), .o_done(done), .o_remaining(remaining)
   );

   assign mem_rdata = mem_rd ? dmem[mem_addr] : 8'h00;

   always @(posedge clk) begin
      if (mem_wr_en) dmem[mem_addr] <= mem_wdata;
      else if (bd_we) dmem[bd_addr] <= bd_data;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] v);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = v;
      @(negedge clk);
      bd_we = 1'b0;
      refm[a] = v;
   endtask

   // memmove reference: snapshot the source, then write the destination
   task automatic model_move(input logic [7:0] s, input logic [7:0] d, input int l);
      logic [7:0] tmp [256];
      logic [7:0] a;
      for (int i = 0; i < l; i++) begin a = s + 8'(i); tmp[i] = refm[a]; end
      for (int i = 0; i < l; i++) begin a = d + 8'(i); refm[a] = tmp[i]; end
   endtask

   task automatic compare_mem(input string name);
      int bad = -1;
      for (int i = 0; i < 256; i++)
         if (bad < 0 && dmem[i] !== refm[i]) bad = i;
      checks++;
      if (bad >= 0) begin
         errors++;
         $display("FAIL %s: mem[%0h] got %0h expected %0h", name, bad, dmem[bad], refm[bad]);
      end
   endtask

   // Issue one command and observe it until busy falls. Returns latency (edge
   // count from the accepting edge, which counts as 1, to the done-high cycle).
   task automatic run_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input bit inj_busy, output int lat, output int nwr,
                          output logic [7:0] fw, output logic [7:0] lw, output int ndone);
      int k;
      int rem_bad;
      lat = 0; nwr = 0; ndone = 0; fw = '0; lw = '0; rem_bad = 0;
      @(negedge clk);
      start = 1'b1; src = s; dst = d; len = l;
      @(posedge clk); #1;
      start = 1'b0;
      k = 1;
      while (k <= 700) begin
         if (remaining !== 8'(int'(l) - nwr)) rem_bad++;
         if (mem_wr_en) begin
            if (nwr == 0) fw = mem_addr;
            lw = mem_addr;
            nwr++;
         end
         if (done) begin
            ndone++;
            if (lat == 0) lat = k;
         end
         if (!busy) break;
         if (inj_busy && k == 3) begin
            start = 1'b1; src = s ^ 8'h5A; dst = d ^ 8'hA5; len = 8'd2;
         end
         if (inj_busy && k == 4) start = 1'b0;
         @(posedge clk); #1;
         k++;
      end
      start = 1'b0;
      check("cmd_timeout", (k > 700) ? 1 : 0, 0);
      check("remaining_track", rem_bad, 0);
      check("idle_after_cmd", {busy, done, mem_rd, mem_wr_en}, 0);
   endtask

   typedef struct {
      logic [7:0] s, d, l, fw, lw;
      int         lat;
   } vec_t;

   vec_t vt [8];
   int   lat, nwr, ndone;
   logic [7:0] fw, lw;

   initial begin
      vt[0] = '{8'h10, 8'h40, 8'd4,   8'h40, 8'h43, 9};
      vt[1] = '{8'h20, 8'h22, 8'd3,   8'h24, 8'h22, 7};
      vt[2] = '{8'h22, 8'h20, 8'd3,   8'h20, 8'h22, 7};
      vt[3] = '{8'hFE, 8'h80, 8'd4,   8'h80, 8'h83, 9};
      vt[4] = '{8'h05, 8'h06, 8'd0,   8'h00, 8'h00, 1};
      vt[5] = '{8'h30, 8'h30, 8'd2,   8'h30, 8'h31, 5};
      vt[6] = '{8'hFE, 8'h00, 8'd4,   8'h03, 8'h00, 9};
      vt[7] = '{8'h00, 8'h01, 8'd255, 8'hFF, 8'h01, 511};

      #2;
      check("rst_outputs", {mem_addr, mem_rd, mem_wr_en, mem_wdata, busy, done, remaining}, 0);
      @(negedge clk); rst_n = 1'b1;

      for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
      poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);
      for (int i = 0; i < 5; i++) poke(8'h20 + 8'(i), 8'(i + 1));
      compare_mem("preload");

      for (int v = 0; v < 8; v++) begin
         run_cmd(vt[v].s, vt[v].d, vt[v].l, 1'b0, lat, nwr, fw, lw, ndone);
         model_move(vt[v].s, vt[v].d, int'(vt[v].l));
         check($sformatf("vec%0d_latency", v), lat, vt[v].lat);
         check($sformatf("vec%0d_done_count", v), ndone, 1);
         check($sformatf("vec%0d_write_count", v), nwr, int'(vt[v].l));
         if (vt[v].l != 0) begin
            check($sformatf("vec%0d_first_wr", v), fw, vt[v].fw);
            check($sformatf("vec%0d_last_wr", v), lw, vt[v].lw);
         end
         compare_mem($sformatf("vec%0d_mem", v));
         if (v == 0)
            check("fwd_dst_bytes", {dmem[8'h40], dmem[8'h41], dmem[8'h42], dmem[8'h43]}, 32'hA1B2C3D4);
         if (v == 1)
            check("bwd_dst_bytes", {dmem[8'h22], dmem[8'h23], dmem[8'h24]}, 24'h010203);
         if (v == 2)
            check("ovl_fwd_bytes", {dmem[8'h20], dmem[8'h21], dmem[8'h22]}, 24'h010203);
      end

      // start pulsed while busy must not disturb the running command
      run_cmd(8'h60, 8'hC0, 8'd4, 1'b1, lat, nwr, fw, lw, ndone);
      model_move(8'h60, 8'hC0, 4);
      check("busy_start_latency", lat, 9);
      check("busy_start_done_count", ndone, 1);
      check("busy_start_writes", nwr, 4);
      compare_mem("busy_start_mem");

      // reset during the WRITE of byte 2 of a len=5 copy
      for (int i = 0; i < 5; i++) poke(8'h50 + 8'(i), 8'(8'h11 * (i + 1)));
      for (int i = 0; i < 5; i++) poke(8'h90 + 8'(i), 8'hEE);
      @(negedge clk);
      start = 1'b1; src = 8'h50; dst = 8'h90; len = 8'd5;
      @(posedge clk); #1;
      start = 1'b0;
      begin
         int k = 0;
         int seen_done = 0;
         while (!(mem_wr_en && mem_addr == 8'h92) && k < 50) begin
            if (done) seen_done++;
            @(posedge clk); #1;
            k++;
         end
         check("rst_wait_timeout", (k >= 50) ? 1 : 0, 0);
         #1 rst_n = 1'b0;
         #1;
         check("rst_mid_wr_en", mem_wr_en, 0);
         check("rst_mid_busy_rem", {busy, remaining}, 0);
         @(posedge clk); #1;
         if (done) seen_done++;
         @(negedge clk); rst_n = 1'b1;
         @(posedge clk); #1;
         if (done) seen_done++;
         check("rst_no_done", seen_done, 0);
      end
      refm[8'h90] = 8'h11; refm[8'h91] = 8'h22;
      compare_mem("rst_partial_mem");

      run_cmd(8'h50, 8'hA0, 8'd5, 1'b0, lat, nwr, fw, lw, ndone);
      model_move(8'h50, 8'hA0, 5);
      check("post_rst_latency", lat, 11);
      check("post_rst_done_count", ndone, 1);
      compare_mem("post_rst_mem");

      // randomized commands against the memmove model
      for (int r = 0; r < 30; r++) begin
         logic [7:0] rs, rd, rl;
         rs = 8'($urandom);
         rd = (r % 3 == 0) ? rs + 8'($urandom_range(0, 8)) : 8'($urandom);
         rl = 8'($urandom_range(0, 20));
         run_cmd(rs, rd, rl, 1'b0, lat, nwr, fw, lw, ndone);
         model_move(rs, rd, int'(rl));
         check("rand_latency", lat, (rl == 0) ? 1 : 2 * int'(rl) + 1);
         check("rand_done_count", ndone, 1);
         check("rand_writes", nwr, int'(rl));
         compare_mem("rand_mem");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
